// File: rtl/fifo_arb_pkg.sv
// Shared types, constants and round-robin index helper for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int STATS_CNT_W = 16;
  localparam int RR_MAX_REQ  = 32;

  // First set bit of mask scanning start, start+1, ... wrapping at n; -1 when mask is empty.
  function automatic int rr_next(input logic [RR_MAX_REQ-1:0] mask, input int start, input int n);
    int idx;
    int result;
    result = -1;
    for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (mask[idx[4:0]]) result = idx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Combinational round-robin picker: first asserted request at or after a start index.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          hit,
  output logic [IW-1:0] idx
);

  int pick;

  always_comb begin
    pick = rr_next(RR_MAX_REQ'(req), int'(start), N);
    hit  = (pick >= 0);
    idx  = hit ? IW'(pick) : '0;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port; beats tagged with source ID.
// Define FIFO_ARB_STATS_EN to add saturating per-requester written-beat counters (beat_count).
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int ID_W      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_w_en,
  output logic [ID_W+DATA_WIDTH-1:0]     fifo_data,
  output logic                           grant_valid,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*STATS_CNT_W-1:0] beat_count,
`endif
  output logic [ID_W-1:0]                grant_id
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  TOP_ID    = ID_W'(NUM_REQ - 1);

  arb_state_t            state_reg, state_next;
  logic [ID_W-1:0]       grant_id_reg, grant_id_next;
  logic [ID_W-1:0]       last_ptr_reg, last_ptr_next;
  logic [CNT_W-1:0]      beat_cnt_reg, beat_cnt_next;
  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic                  in_burst, owner_valid, xfer, burst_end;
  logic [ID_W-1:0]       pick_base, pick_start, pick_idx;
  logic                  pick_hit;

  // Handshakes are gated by rst_n so a beat in flight during reset is never written.
  assign in_burst    = (state_reg == ARB_BURST) & rst_n;
  assign owner_valid = req_valid[grant_id_reg];
  assign xfer        = in_burst & owner_valid & ~fifo_full;
  assign burst_end   = in_burst & ((xfer & (beat_cnt_reg == LAST_BEAT)) | ~owner_valid);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi]    = in_burst & (grant_id_reg == ID_W'(gi)) & ~fifo_full;
    end
  endgenerate

  assign fifo_w_en   = xfer;
  assign fifo_data   = {grant_id_reg, req_data_arr[grant_id_reg]};
  assign grant_valid = (state_reg == ARB_BURST);
  assign grant_id    = grant_id_reg;

  // Scanning from owner+1 leaves the ending owner last in line: re-granted only when alone.
  assign pick_base  = (state_reg == ARB_IDLE) ? last_ptr_reg : grant_id_reg;
  assign pick_start = (pick_base == TOP_ID) ? '0 : pick_base + ID_W'(1);

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_picker (
    .req   (req_valid),
    .start (pick_start),
    .hit   (pick_hit),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next    = state_reg;
    grant_id_next = grant_id_reg;
    last_ptr_next = last_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_hit) begin
          state_next    = ARB_BURST;
          grant_id_next = pick_idx;
          beat_cnt_next = '0;
        end
      end
      ARB_BURST: begin
        if (burst_end) begin
          last_ptr_next = grant_id_reg;
          beat_cnt_next = '0;
          if (pick_hit) grant_id_next = pick_idx;
          else          state_next    = ARB_IDLE;
        end else if (xfer) begin
          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ARB_IDLE;
      grant_id_reg <= '0;
      last_ptr_reg <= TOP_ID;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_id_reg <= grant_id_next;
      last_ptr_reg <= last_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [STATS_CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)
          cnt_reg <= '0;
        else if (req_ready[gi] & req_valid[gi] & (cnt_reg != '1))
          cnt_reg <= cnt_reg + STATS_CNT_W'(1);
      end
      assign beat_count[gi*STATS_CNT_W +: STATS_CNT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: cycle model plus directed literal expectations.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_w_en;
  logic [IW+DW-1:0]  fifo_data;
  logic              grant_valid;
  logic [IW-1:0]     grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0]  beat_count;
`endif

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_data   (fifo_data),
    .grant_valid (grant_valid),
`ifdef FIFO_ARB_STATS_EN
    .beat_count  (beat_count),
`endif
    .grant_id    (grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Producers: beats left to send and the payload of the head beat.
  int             remaining [NR];
  logic [DW-1:0]  next_val  [NR];
  bit             xfer      [NR];

  // Model: whether a grant is held, its owner, beats used in it, last owner.
  bit m_gv;
  int m_gid, m_cnt, m_last;

  // DUT writes seen: source id and cycle.
  int log_id [$];
  int log_cyc [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = (remaining[i] > 0);
      req_data[i*DW +: DW] = next_val[i];
    end
  endtask

  function automatic int scan_from(input int after, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(after + k) % NR]) return (after + k) % NR;
    return -1;
  endfunction

  // One clock: compare at negedge, advance model, then update producers after the edge.
  task automatic step();
    bit            exp_wen;
    logic [NR-1:0] exp_rdy;
    bit            done;
    int            w;
    @(negedge clk);
    exp_wen = rst_n && m_gv && req_valid[m_gid] && !fifo_full;
    for (int i = 0; i < NR; i++) exp_rdy[i] = rst_n && m_gv && (i == m_gid) && !fifo_full;
    check("grant_valid", grant_valid, m_gv);
    if (m_gv) check("grant_id", grant_id, m_gid);
    check("fifo_w_en", fifo_w_en, exp_wen);
    check("req_ready", req_ready, exp_rdy);
    if (exp_wen) check("fifo_data", fifo_data, {IW'(m_gid), next_val[m_gid]});
    if (fifo_w_en) begin
      log_id.push_back(int'(fifo_data[DW +: IW]));
      log_cyc.push_back(cyc);
    end
    for (int i = 0; i < NR; i++) xfer[i] = req_valid[i] && req_ready[i];
    if (!rst_n) begin
      m_gv = 0; m_gid = 0; m_cnt = 0; m_last = NR - 1;
    end else if (!m_gv) begin
      w = scan_from(m_last, req_valid);
      if (w >= 0) begin m_gv = 1; m_gid = w; m_cnt = 0; end
    end else begin
      if (exp_wen) m_cnt++;
      done = (exp_wen && m_cnt == MB) || !req_valid[m_gid];
      if (done) begin
        m_last = m_gid;
        m_cnt  = 0;
        w = scan_from(m_gid, req_valid);
        if (w >= 0) m_gid = w;
        else        m_gv  = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++)
      if (xfer[i]) begin remaining[i]--; next_val[i]++; end
    drive();
  endtask

  task automatic run_writes(input int n, input int budget, input string name);
    int b = 0;
    while (log_id.size() < n && b < budget) begin step(); b++; end
    check(name, log_id.size(), n);
  endtask

  task automatic drain();
    for (int i = 0; i < NR; i++) remaining[i] = 0;
    drive();
    repeat (3) step();
    check("drain_idle", grant_valid, 1'b0);
  endtask

  task automatic clear_log();
    log_id.delete();
    log_cyc.delete();
  endtask

  int t2_ids [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
  int t3_ids [5]  = '{1,1,2,2,2};

  initial begin
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      remaining[i] = 0;
      next_val[i]  = DW'(i * 64);
    end
    m_gv = 0; m_gid = 0; m_cnt = 0; m_last = NR - 1;
    drive();
    step();
    step();
    check("rst_grant_valid", grant_valid, 1'b0);
    check("rst_grant_id", grant_id, 0);
    check("rst_w_en", fifo_w_en, 1'b0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;

    // T2: full contention, bursts of 4 rotate with no bubble.
    clear_log();
    for (int i = 0; i < NR; i++) remaining[i] = 5;
    drive();
    run_writes(17, 40, "t2_write_count");
    for (int k = 0; k < 17 && k < log_id.size(); k++) begin
      check("t2_id", log_id[k], t2_ids[k]);
      check("t2_contiguous", log_cyc[k] - log_cyc[0], k);
    end
    drain();

    // T1: reset mid-burst, then req 0 wins first again.
    for (int i = 0; i < NR; i++) remaining[i] = 10;
    drive();
    repeat (4) step();
    check("t1_burst_active", grant_valid, 1'b1);
    rst_n = 1'b0;
    step();
    step();
    check("t1_rst_grant_valid", grant_valid, 1'b0);
    check("t1_rst_w_en", fifo_w_en, 1'b0);
    rst_n = 1'b1;
    step();
    check("t1_first_grant_valid", grant_valid, 1'b1);
    check("t1_first_grant_id", grant_id, 0);
    drain();

    // T3: owner drops valid after 2 beats, grant moves to req 2 without idling.
    clear_log();
    remaining[1] = 2;
    remaining[2] = 3;
    drive();
    run_writes(5, 20, "t3_write_count");
    for (int k = 0; k < 5 && k < log_id.size(); k++) check("t3_id", log_id[k], t3_ids[k]);
    if (log_cyc.size() >= 3) check("t3_handover_gap", log_cyc[2] - log_cyc[1], 2);
    drain();

    // T4: fifo_full stalls mid-burst for 5 cycles, grant held, burst resumes.
    clear_log();
    remaining[0] = 6;
    drive();
    run_writes(2, 10, "t4_pre_full_count");
    fifo_full = 1'b1;
    repeat (5) begin
      step();
      check("t4_full_ready", req_ready, 0);
      check("t4_full_w_en", fifo_w_en, 1'b0);
      check("t4_full_grant_id", grant_id, 0);
      check("t4_full_grant_valid", grant_valid, 1'b1);
    end
    fifo_full = 1'b0;
    run_writes(6, 20, "t4_write_count");
    for (int k = 0; k < log_id.size(); k++) check("t4_id", log_id[k], 0);
    if (log_cyc.size() >= 6) begin
      check("t4_stall_gap", log_cyc[2] - log_cyc[1], 6);
      check("t4_resume_contiguous", log_cyc[5] - log_cyc[2], 3);
    end
    drain();

    // T5: sole requester re-granted to itself, 10 contiguous writes.
    clear_log();
    remaining[3] = 10;
    drive();
    run_writes(10, 30, "t5_write_count");
    for (int k = 0; k < log_id.size(); k++) check("t5_id", log_id[k], 3);
    if (log_cyc.size() >= 10) check("t5_contiguous", log_cyc[9] - log_cyc[0], 9);
    drain();

`ifdef FIFO_ARB_STATS_EN
    // T6: counters clear on reset and count 8 beats per requester over 32 beats.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("t6_cleared", beat_count, 0);
    clear_log();
    for (int i = 0; i < NR; i++) remaining[i] = 8;
    drive();
    run_writes(32, 60, "t6_write_count");
    drain();
    for (int i = 0; i < NR; i++) check("t6_beat_count", beat_count[i*16 +: 16], 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
